// File: rtl/timer_prog_if.sv
// Control/status bundle for timer_prog.
// The optional irq/irq_clear pair exists only when TIMER_PROG_IRQ_EN is defined.
interface timer_prog_if #(
  parameter int unsigned BITS     = 16,
  parameter int unsigned PRE_BITS = 8
);
  logic                enable;
  logic                start;
  logic                stop;
  logic                mode;
  logic [BITS-1:0]     final_value;
  logic [PRE_BITS-1:0] prescale;
  logic [BITS-1:0]     count;
  logic                busy;
  logic                done;
`ifdef TIMER_PROG_IRQ_EN
  logic                irq;
  logic                irq_clear;

  modport master (
    output enable, start, stop, mode, final_value, prescale, irq_clear,
    input  count, busy, done, irq
  );
  modport slave (
    input  enable, start, stop, mode, final_value, prescale, irq_clear,
    output count, busy, done, irq
  );
`else
  modport master (
    output enable, start, stop, mode, final_value, prescale,
    input  count, busy, done
  );
  modport slave (
    input  enable, start, stop, mode, final_value, prescale,
    output count, busy, done
  );
`endif
endinterface

// File: rtl/timer_prog.sv
// Programmable up-counting interval timer with prescaler, one-shot/periodic modes and
// start/stop control. Period = (final_value+1)*(prescale+1) enabled clk cycles.
// Optional sticky irq flag: define TIMER_PROG_IRQ_EN.
module timer_prog #(
  parameter int unsigned BITS     = 16,
  parameter int unsigned PRE_BITS = 8
) (
  input logic         clk,
  input logic         reset_n,
  timer_prog_if.slave bus
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  logic [0:0]          state_q, state_d;
  logic [BITS-1:0]     count_q, count_d;
  logic [BITS-1:0]     final_q, final_d;
  logic [PRE_BITS-1:0] pre_cnt_q, pre_cnt_d;
  logic [PRE_BITS-1:0] pre_q, pre_d;
  logic                mode_q, mode_d;
  logic                done_q, done_d;
  logic                tick;
  logic                expiry;

  // Prescaler terminal and counter terminal; start/stop pre-empt any expiry this cycle.
  always_comb begin
    tick   = (state_q == StRun) && bus.enable && (pre_cnt_q == pre_q);
    expiry = tick && (count_q == final_q) && !bus.start && !bus.stop;
  end

  // Next-state: stop beats start, start beats counting.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    final_d   = final_q;
    pre_cnt_d = pre_cnt_q;
    pre_d     = pre_q;
    mode_d    = mode_q;
    done_d    = 1'b0;
    if (bus.stop) begin
      state_d = StIdle;
    end else if (bus.start) begin
      final_d   = bus.final_value;
      pre_d     = bus.prescale;
      mode_d    = bus.mode;
      count_d   = '0;
      pre_cnt_d = '0;
      state_d   = StRun;
    end else if ((state_q == StRun) && bus.enable) begin
      if (tick) begin
        pre_cnt_d = '0;
        if (count_q == final_q) begin
          count_d = '0;
          done_d  = 1'b1;
          if (!mode_q) begin
            state_d = StIdle;
          end
        end else begin
          count_d = count_q + BITS'(1);
        end
      end else begin
        pre_cnt_d = pre_cnt_q + PRE_BITS'(1);
      end
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      count_q   <= '0;
      final_q   <= '0;
      pre_cnt_q <= '0;
      pre_q     <= '0;
      mode_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      final_q   <= final_d;
      pre_cnt_q <= pre_cnt_d;
      pre_q     <= pre_d;
      mode_q    <= mode_d;
      done_q    <= done_d;
    end
  end

  assign bus.count = count_q;
  assign bus.busy  = (state_q == StRun);
  assign bus.done  = done_q;

`ifdef TIMER_PROG_IRQ_EN
  logic irq_q, irq_d;

  // Sticky flag: set on expiry, cleared by irq_clear; set wins on collision.
  always_comb begin
    irq_d = irq_q;
    if (bus.irq_clear) begin
      irq_d = 1'b0;
    end
    if (expiry) begin
      irq_d = 1'b1;
    end
  end

  // Interrupt flag register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign bus.irq = irq_q;
`endif

endmodule

// File: tb/tb_timer_prog.sv
// Self-checking bench for timer_prog: behavioural model based on elapsed enabled cycles,
// per-cycle compare process, directed scenarios with literal expectations, random phase.
module tb_timer_prog;
  localparam int unsigned BITS     = 8;
  localparam int unsigned PRE_BITS = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b1;

  timer_prog_if #(.BITS(BITS), .PRE_BITS(PRE_BITS)) bus ();

  timer_prog #(.BITS(BITS), .PRE_BITS(PRE_BITS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Model state: configuration plus enabled cycles elapsed within the current period.
  bit     m_run;
  int     m_f;
  int     m_p;
  bit     m_mode;
  longint m_el;
  int     m_count;
  bit     m_done;
  bit     m_irq;
  int     done_at[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_run   = 1'b0;
    m_f     = 0;
    m_p     = 0;
    m_mode  = 1'b0;
    m_el    = 0;
    m_count = 0;
    m_done  = 1'b0;
    m_irq   = 1'b0;
  endfunction

  function automatic void model_step();
    bit     nd;
    longint per;
    nd = 1'b0;
    if (bus.stop) begin
      m_run = 1'b0;
    end else if (bus.start) begin
      m_f     = int'(bus.final_value);
      m_p     = int'(bus.prescale);
      m_mode  = bus.mode;
      m_el    = 0;
      m_count = 0;
      m_run   = 1'b1;
    end else if (m_run && bus.enable) begin
      m_el++;
      per     = longint'(m_f + 1) * longint'(m_p + 1);
      m_count = int'((m_el / (m_p + 1)) % (m_f + 1));
      if (m_el == per) begin
        nd   = 1'b1;
        m_el = 0;
        if (!m_mode) m_run = 1'b0;
      end
    end
    m_done = nd;
`ifdef TIMER_PROG_IRQ_EN
    if (nd) m_irq = 1'b1;
    else if (bus.irq_clear) m_irq = 1'b0;
`endif
  endfunction

  initial model_reset();

  // Model advance on each active edge.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (reset_n) model_step();
  end

  // Asynchronous reset hits the model immediately.
  initial forever begin
    @(negedge reset_n);
    model_reset();
  end

  // Compare process: outputs against model every cycle, on the inactive edge.
  initial forever begin
    @(negedge clk);
    chk("count", 32'(bus.count), 32'(m_count));
    chk("busy", 32'(bus.busy), 32'(m_run));
    chk("done", 32'(bus.done), 32'(m_done));
`ifdef TIMER_PROG_IRQ_EN
    chk("irq", 32'(bus.irq), 32'(m_irq));
`endif
    if (bus.done === 1'b1) done_at.push_back(cyc);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_t(input int f, input int p, input bit m, output int s);
    bus.final_value = BITS'(f);
    bus.prescale    = PRE_BITS'(p);
    bus.mode        = m;
    bus.start       = 1'b1;
    @(posedge clk);
    #1;
    s               = cyc;
    bus.start       = 1'b0;
    // Scramble config after the start edge; it must be ignored.
    bus.final_value = BITS'($urandom);
    bus.prescale    = PRE_BITS'($urandom);
    bus.mode        = 1'($urandom);
  endtask

  task automatic stop_t();
    bus.stop = 1'b1;
    step(1);
    bus.stop = 1'b0;
  endtask

  function automatic int done_idx(input int i);
    if (done_at.size() > i) return done_at[i];
    return -1000000;
  endfunction

  int s;

  initial begin
    bus.enable      = 1'b1;
    bus.start       = 1'b0;
    bus.stop        = 1'b0;
    bus.mode        = 1'b0;
    bus.final_value = '0;
    bus.prescale    = '0;
`ifdef TIMER_PROG_IRQ_EN
    bus.irq_clear   = 1'b0;
`endif
    #1 reset_n = 1'b0;
    step(2);
    reset_n = 1'b1;
    step(2);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_count", 32'(bus.count), 32'd0);

    // Reset mid-run.
    start_t(4, 2, 1'b1, s);
    step(10);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_count", 32'(bus.count), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    step(5);
    chk("postrst_busy", 32'(bus.busy), 32'd0);

    // Periodic: final=4, pre=2 -> period 15.
    done_at.delete();
    start_t(4, 2, 1'b1, s);
    step(50);
    chk("per_ndone", 32'(done_at.size()), 32'd3);
    chk("per_first", 32'(done_idx(0) - s), 32'd15);
    chk("per_period", 32'(done_idx(1) - done_idx(0)), 32'd15);
    stop_t();

    // One-shot: final=3, pre=0 -> single done 4 cycles after start.
    done_at.delete();
    start_t(3, 0, 1'b0, s);
    step(20);
    chk("os_ndone", 32'(done_at.size()), 32'd1);
    chk("os_first", 32'(done_idx(0) - s), 32'd4);
    chk("os_busy", 32'(bus.busy), 32'd0);
    chk("os_count", 32'(bus.count), 32'd0);

    // Pause 5 cycles mid-run delays expiry by 5.
    done_at.delete();
    start_t(4, 2, 1'b1, s);
    step(6);
    bus.enable = 1'b0;
    step(5);
    bus.enable = 1'b1;
    step(15);
    chk("pause_first", 32'(done_idx(0) - s), 32'd20);
    // stop and start together: stop wins.
    bus.final_value = 8'd7;
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    step(1);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    chk("ss_busy", 32'(bus.busy), 32'd0);
    step(3);
    chk("ss_busy_hold", 32'(bus.busy), 32'd0);

    // final=0, pre=0: done every cycle after the first.
    done_at.delete();
    start_t(0, 0, 1'b1, s);
    step(12);
    chk("f0_first", 32'(done_idx(0) - s), 32'd1);
    chk("f0_ndone", 32'(done_at.size()), 32'd11);
    stop_t();

    // final=all-ones, pre=0: full 256-cycle period.
    done_at.delete();
    start_t(255, 0, 1'b1, s);
    step(520);
    chk("ff_first", 32'(done_idx(0) - s), 32'd256);
    chk("ff_period", 32'(done_idx(1) - done_idx(0)), 32'd256);
    chk("ff_ndone", 32'(done_at.size()), 32'd2);
    stop_t();

`ifdef TIMER_PROG_IRQ_EN
    // Lone clear, then clear colliding with expiry.
    bus.irq_clear = 1'b1;
    step(1);
    bus.irq_clear = 1'b0;
    chk("irq_clr0", 32'(bus.irq), 32'd0);
    start_t(0, 0, 1'b1, s);
    step(2);
    chk("irq_set", 32'(bus.irq), 32'd1);
    bus.irq_clear = 1'b1;
    step(1);
    bus.irq_clear = 1'b0;
    chk("irq_collide", 32'(bus.irq), 32'd1);
    stop_t();
    bus.irq_clear = 1'b1;
    step(1);
    bus.irq_clear = 1'b0;
    chk("irq_clr1", 32'(bus.irq), 32'd0);
`endif

    // Random phase, checked by the compare process.
    repeat (400) begin
      bus.start       = ($urandom_range(0, 19) == 0);
      bus.stop        = ($urandom_range(0, 29) == 0);
      bus.enable      = ($urandom_range(0, 4) != 0);
      bus.mode        = 1'($urandom);
      bus.final_value = BITS'($urandom_range(0, 7));
      bus.prescale    = PRE_BITS'($urandom_range(0, 3));
`ifdef TIMER_PROG_IRQ_EN
      bus.irq_clear   = ($urandom_range(0, 9) == 0);
`endif
      step(1);
    end
    bus.start = 1'b0;
    bus.stop  = 1'b0;
`ifdef TIMER_PROG_IRQ_EN
    bus.irq_clear = 1'b0;
`endif
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
